// File: rtl/bitblaster_controller.sv
// bitblaster_controller: timestep sequencer that latches an instruction and issues
// register-file, bus and ALU controls decoded from the current timestep and IR.
module bitblaster_controller (
    input  logic       CLKb,
    input  logic       Clr,
    input  logic       Exec,
    input  logic [9:0] INSTR,
    output logic [9:0] IR,
    output logic       ENW,
    output logic       ENR0,
    output logic       ENR1,
    output logic [1:0] WRA,
    output logic [1:0] RDA0,
    output logic [1:0] RDA1,
    output logic       Extrn,
    output logic       Ain,
    output logic       Gin,
    output logic       Gout,
    output logic [3:0] ALU_FN,
    output logic       Busy,
    output logic       Done,
    output logic [1:0] T
);
    typedef enum logic [1:0] {T0, T1, T2, T3} tstep_e;
    tstep_e     t_q;
    logic [9:0] ir_q;
    logic [3:0] op;
    logic [1:0] rx, ry;
    logic       is_alu, is_load, is_copy, in_t1, in_t2, in_t3;
    assign op      = ir_q[9:6];
    assign rx      = ir_q[5:4];
    assign ry      = ir_q[3:2];
    assign is_alu  = !op[3] && (op[2:1] != 2'b00);
    assign is_load = (op == 4'b0000);
    assign is_copy = (op == 4'b0001);
    assign in_t1   = (t_q == T1);
    assign in_t2   = (t_q == T2);
    assign in_t3   = (t_q == T3);
    // Exec is only looked at in T0, so requests during an operation are dropped.
    always_ff @(posedge CLKb or posedge Clr) begin
        if (Clr) begin
            t_q  <= T0;
            ir_q <= '0;
        end else begin
            case (t_q)
                T0: if (Exec) begin
                    t_q  <= T1;
                    ir_q <= INSTR;
                end
                T1: t_q <= is_alu ? T2 : T0;
                T2: t_q <= T3;
                default: t_q <= T0;
            endcase
        end
    end
    assign IR     = ir_q;
    assign T      = t_q;
    assign Busy   = (t_q != T0);
    assign Extrn  = in_t1 && is_load;
    assign ENR0   = in_t1 && (is_copy || is_alu);
    assign RDA0   = ENR0 ? (is_copy ? ry : rx) : 2'b00;
    assign Ain    = in_t1 && is_alu;
    assign ENR1   = in_t2 && is_alu;
    assign RDA1   = ENR1 ? ry : 2'b00;
    assign Gin    = in_t2 && is_alu;
    assign ALU_FN = Gin ? op : 4'b0000;
    assign Gout   = in_t3 && is_alu;
    // The single register write always coincides with the final step.
    assign ENW    = (in_t1 && (is_load || is_copy)) || (in_t3 && is_alu);
    assign WRA    = ENW ? rx : 2'b00;
    assign Done   = (in_t1 && !is_alu) || (in_t3 && is_alu);
endmodule

// File: tb/tb_bitblaster_controller.sv
// tb_bitblaster_controller: randomized checks against a queue-of-steps model of
// the instruction sequencing, plus directed load/add/nop/hold/abort scenarios.
module tb_bitblaster_controller;
    logic       CLKb, Clr, Exec;
    logic [9:0] INSTR, IR;
    logic       ENW, ENR0, ENR1, Extrn, Ain, Gin, Gout, Busy, Done;
    logic [1:0] WRA, RDA0, RDA1, T;
    logic [3:0] ALU_FN;

    typedef struct packed {
        logic [9:0] ir;
        logic       enw, enr0, enr1;
        logic [1:0] wra, rda0, rda1;
        logic       extrn, ain, gin, gout;
        logic [3:0] fn;
        logic       busy, done;
        logic [1:0] t;
    } exp_t;

    exp_t       obs;
    exp_t       pend[$];
    logic [9:0] m_ir;
    int         errors = 0;
    int         checks = 0;
    int         enw_cnt = 0;

    bitblaster_controller dut (
        .CLKb(CLKb), .Clr(Clr), .Exec(Exec), .INSTR(INSTR), .IR(IR),
        .ENW(ENW), .ENR0(ENR0), .ENR1(ENR1), .WRA(WRA), .RDA0(RDA0), .RDA1(RDA1),
        .Extrn(Extrn), .Ain(Ain), .Gin(Gin), .Gout(Gout), .ALU_FN(ALU_FN),
        .Busy(Busy), .Done(Done), .T(T)
    );

    assign obs = {IR, ENW, ENR0, ENR1, WRA, RDA0, RDA1, Extrn, Ain, Gin, Gout, ALU_FN, Busy, Done, T};

    initial begin
        CLKb = 0;
        forever #5 CLKb = ~CLKb;
    end

    always @(posedge CLKb) if (ENW === 1'b1) enw_cnt++;

    // Expected per-cycle output vectors for one accepted instruction.
    task automatic push_seq(input logic [9:0] ins);
        exp_t v;
        logic [3:0] op;
        logic [1:0] rx, ry;
        op = ins[9:6];
        rx = ins[5:4];
        ry = ins[3:2];
        v = '0;
        v.ir = ins;
        v.busy = 1;
        v.t = 2'd1;
        if (op >= 4'd8) begin
            v.done = 1;
            pend.push_back(v);
        end else if (op == 4'd0) begin
            v.extrn = 1; v.enw = 1; v.wra = rx; v.done = 1;
            pend.push_back(v);
        end else if (op == 4'd1) begin
            v.enr0 = 1; v.rda0 = ry; v.enw = 1; v.wra = rx; v.done = 1;
            pend.push_back(v);
        end else begin
            v.enr0 = 1; v.rda0 = rx; v.ain = 1;
            pend.push_back(v);
            v = '0; v.ir = ins; v.busy = 1; v.t = 2'd2;
            v.enr1 = 1; v.rda1 = ry; v.gin = 1; v.fn = op;
            pend.push_back(v);
            v = '0; v.ir = ins; v.busy = 1; v.t = 2'd3;
            v.gout = 1; v.enw = 1; v.wra = rx; v.done = 1;
            pend.push_back(v);
        end
    endtask

    function automatic exp_t exp_now();
        exp_t v;
        v = '0;
        v.ir = m_ir;
        return (pend.size() != 0) ? pend[0] : v;
    endfunction

    // Drive one clock edge from a negedge and advance the model; returns at the next negedge.
    task automatic tick(input logic e, input logic [9:0] ins);
        Exec = e;
        INSTR = ins;
        @(posedge CLKb);
        if (pend.size() != 0) void'(pend.pop_front());
        else if (e) begin
            m_ir = ins;
            push_seq(ins);
        end
        @(negedge CLKb);
    endtask

    task automatic test_reset();
        Clr = 1; Exec = 1; INSTR = 10'h3FF;
        repeat (2) @(posedge CLKb);
        @(negedge CLKb);
        checks++;
        if (obs !== 31'd0) begin errors++; $display("FAIL reset_hold obs=%h exp=0", obs); end
        Clr = 0;
        tick(0, 10'h155);
        checks++;
        if (obs !== exp_now()) begin errors++; $display("FAIL reset_idle obs=%h exp=%h", obs, exp_now()); end
    endtask

    task automatic test_load();
        tick(1, 10'b0000_10_00_00);
        checks++;
        if (obs !== exp_now()) begin errors++; $display("FAIL load_t1 obs=%h exp=%h", obs, exp_now()); end
        checks++;
        if (T !== 2'd1 || WRA !== 2'd2 || !Extrn || !ENW || !Done) begin
            errors++; $display("FAIL load_fields T=%0d WRA=%0d exp T=1 WRA=2", T, WRA);
        end
        tick(0, 10'h0);
        checks++;
        if (obs !== exp_now() || T !== 2'd0) begin errors++; $display("FAIL load_ret obs=%h exp=%h", obs, exp_now()); end
    endtask

    task automatic test_add();
        tick(1, 10'b0010_01_11_00);
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (obs !== exp_now()) begin errors++; $display("FAIL add_step%0d obs=%h exp=%h", i, obs, exp_now()); end
            tick(0, 10'h0);
        end
    endtask

    task automatic test_nop();
        tick(1, 10'b1010_11_01_10);
        checks++;
        if (obs !== exp_now()) begin errors++; $display("FAIL nop_t1 obs=%h exp=%h", obs, exp_now()); end
        checks++;
        if (!Done || ENW || ENR0 || ENR1 || Extrn || Gout) begin
            errors++; $display("FAIL nop_enables Done=%b ENW=%b ENR0=%b ENR1=%b Extrn=%b Gout=%b exp Done only", Done, ENW, ENR0, ENR1, Extrn, Gout);
        end
        tick(0, 10'h0);
    endtask

    task automatic test_exec_held();
        int dones;
        dones = 0;
        tick(1, 10'b0011_10_01_00);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs !== exp_now()) begin errors++; $display("FAIL held_step%0d obs=%h exp=%h", i, obs, exp_now()); end
            if (Done === 1'b1) dones++;
            tick(1, 10'b0000_01_00_00);
        end
        checks++;
        if (dones != 1) begin errors++; $display("FAIL held_dones got=%0d exp=1", dones); end
        checks++;
        if (obs !== exp_now() || T !== 2'd1 || IR !== 10'b0000_01_00_00) begin
            errors++; $display("FAIL held_second obs=%h exp=%h", obs, exp_now());
        end
        tick(0, 10'h0);
    endtask

    task automatic test_clr_abort();
        enw_cnt = 0;
        tick(1, 10'b0011_11_10_00);
        tick(0, 10'h0);
        checks++;
        if (obs !== exp_now() || T !== 2'd2) begin errors++; $display("FAIL sub_t2 obs=%h exp=%h", obs, exp_now()); end
        #2 Clr = 1;
        #1;
        pend.delete();
        m_ir = '0;
        checks++;
        if (obs !== 31'd0) begin errors++; $display("FAIL clr_async obs=%h exp=0", obs); end
        @(negedge CLKb);
        @(negedge CLKb);
        checks++;
        if (obs !== 31'd0) begin errors++; $display("FAIL clr_held obs=%h exp=0", obs); end
        Clr = 0;
        for (int i = 0; i < 2; i++) begin
            tick(0, 10'h0);
            checks++;
            if (obs !== exp_now()) begin errors++; $display("FAIL clr_no_resume obs=%h exp=%h", obs, exp_now()); end
        end
        checks++;
        if (enw_cnt != 0) begin errors++; $display("FAIL clr_enw got=%0d exp=0", enw_cnt); end
        Clr = 1;
        #2 Clr = 0;
        tick(1, 10'b0001_00_11_00);
        checks++;
        if (obs !== exp_now() || T !== 2'd1) begin errors++; $display("FAIL clr_accept obs=%h exp=%h", obs, exp_now()); end
        tick(0, 10'h0);
    endtask

    task automatic test_sweep();
        logic [9:0] ins;
        int writes, drivers, bad;
        bad = 0;
        for (int k = 0; k < 256; k++) begin
            ins = {k[7:0], 2'(($urandom))};
            writes = 0;
            tick(1, ins);
            for (int c = 0; c < 6 && T !== 2'd0; c++) begin
                checks++;
                if (obs !== exp_now()) begin errors++; $display("FAIL sweep_vec ins=%h obs=%h exp=%h", ins, obs, exp_now()); end
                drivers = int'(Extrn) + int'(ENR0) + int'(ENR1) + int'(Gout);
                if (ENW === 1'b1) writes++;
                checks++;
                if (drivers > 1 || (ENW && !Done)) begin
                    errors++; $display("FAIL sweep_bus ins=%h drivers=%0d ENW=%b Done=%b exp drivers<=1 ENW only with Done", ins, drivers, ENW, Done);
                end
                tick(1'($urandom), 10'($urandom));
            end
            checks++;
            if (writes > 1 || T !== 2'd0) begin errors++; $display("FAIL sweep_writes ins=%h writes=%0d T=%0d exp <=1 and T=0", ins, writes, T); end
            if ($urandom_range(0, 3) == 0) tick(0, 10'h0);
        end
    endtask

    initial begin
        m_ir = '0;
        Exec = 0;
        INSTR = '0;
        test_reset();
        test_load();
        test_add();
        test_nop();
        test_exec_held();
        test_clr_abort();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
